// File: rtl/pipeline_fifo_buffer_levels_pkg.sv
// Shared constants and helpers for the pipeline FIFO buffer.
// Holds the occupancy direction codes and a constant-foldable clog2.
package pipeline_fifo_pkg;

   localparam logic [1:0] COUNT_UP   = 2'b10;
   localparam logic [1:0] COUNT_DOWN = 2'b01;

   function automatic int clog2(input int value);
      int result;
      int remaining;
      result = 0;
      for (remaining = value - 1; remaining > 0; remaining = remaining >> 1) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/RAM_Simple_Dual_Port.sv
// Simple dual-port synchronous RAM: one write port, one read port.
// Reads have one cycle of latency and read_data holds between reads.
module RAM_Simple_Dual_Port #(
   parameter int WORD_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int DEPTH      = 16,
   parameter     RAMSTYLE   = "MLAB, no_rw_check"
) (
   input  logic                  clock,
   input  logic                  wren,
   input  logic [ADDR_WIDTH-1:0] write_address,
   input  logic [WORD_WIDTH-1:0] write_data,
   input  logic                  rden,
   input  logic [ADDR_WIDTH-1:0] read_address,
   output logic [WORD_WIDTH-1:0] read_data
);

   (* ramstyle = RAMSTYLE *)
   logic [WORD_WIDTH-1:0] mem_r [DEPTH];

   // Storage write and registered read
   always_ff @(posedge clock) begin
      if (wren) begin
         mem_r[write_address] <= write_data;
      end
      if (rden) begin
         read_data <= mem_r[read_address];
      end
   end

endmodule

// File: rtl/pipeline_fifo_buffer_levels_pointer_ctrl.sv
// Wrapping read/write pointers and the occupancy counter of the FIFO buffer.
// Pointers wrap from DEPTH-1 to 0, so DEPTH need not be a power of two.
module pipeline_fifo_pointer_ctrl
   import pipeline_fifo_pkg::*;
#(
   parameter int DEPTH       = 16,
   parameter int PTR_WIDTH   = 4,
   parameter int COUNT_WIDTH = 5
) (
   input  logic                   clock,
   input  logic                   clear,
   input  logic                   flush,
   input  logic                   insert,
   input  logic                   read_issue,
   input  logic                   remove,
   output logic [PTR_WIDTH-1:0]   write_pointer,
   output logic [PTR_WIDTH-1:0]   read_pointer,
   output logic [COUNT_WIDTH-1:0] count
);

   logic [PTR_WIDTH-1:0]   write_ptr_r;
   logic [PTR_WIDTH-1:0]   read_ptr_r;
   logic [COUNT_WIDTH-1:0] count_r;
   logic [COUNT_WIDTH-1:0] count_next_s;

   function automatic logic [PTR_WIDTH-1:0] wrap_inc(input logic [PTR_WIDTH-1:0] ptr);
      logic [PTR_WIDTH-1:0] result;
      if (ptr == PTR_WIDTH'(DEPTH - 1)) begin
         result = {PTR_WIDTH{1'b0}};
      end else begin
         result = ptr + PTR_WIDTH'(1);
      end
      return result;
   endfunction

   // Occupancy update: a simultaneous insert and remove cancel out
   always_comb begin
      count_next_s = count_r;
      case ({insert, remove})
         COUNT_UP:   count_next_s = count_r + COUNT_WIDTH'(1);
         COUNT_DOWN: count_next_s = count_r - COUNT_WIDTH'(1);
         default:    count_next_s = count_r;
      endcase
   end

   // Pointer and counter registers; flush discards everything
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         write_ptr_r <= {PTR_WIDTH{1'b0}};
         read_ptr_r  <= {PTR_WIDTH{1'b0}};
         count_r     <= {COUNT_WIDTH{1'b0}};
      end else if (flush) begin
         write_ptr_r <= {PTR_WIDTH{1'b0}};
         read_ptr_r  <= {PTR_WIDTH{1'b0}};
         count_r     <= {COUNT_WIDTH{1'b0}};
      end else begin
         if (insert) begin
            write_ptr_r <= wrap_inc(write_ptr_r);
         end
         if (read_issue) begin
            read_ptr_r <= wrap_inc(read_ptr_r);
         end
         count_r <= count_next_s;
      end
   end

   assign write_pointer = write_ptr_r;
   assign read_pointer  = read_ptr_r;
   assign count         = count_r;

endmodule

// File: rtl/pipeline_fifo_buffer_levels.sv
// Ready/valid FIFO buffer with registered output, occupancy count and level flags.
// Optional peak-occupancy tracking is enabled by PIPELINE_FIFO_BUFFER_HIGH_WATER_EN.
module pipeline_fifo_buffer_levels
   import pipeline_fifo_pkg::*;
#(
   parameter int WORD_WIDTH         = 8,
   parameter int DEPTH              = 16,
   parameter int ALMOST_FULL_LEVEL  = DEPTH - 2,
   parameter int ALMOST_EMPTY_LEVEL = 1,
   parameter     RAMSTYLE           = "MLAB, no_rw_check"
) (
   input  logic                          clock,
   input  logic                          clear,
   input  logic                          flush,
   input  logic                          input_valid,
   output logic                          input_ready,
   input  logic [WORD_WIDTH-1:0]         input_data,
   output logic                          output_valid,
   input  logic                          output_ready,
   output logic [WORD_WIDTH-1:0]         output_data,
   output logic [clog2(DEPTH+1)-1:0]     count,
   output logic                          almost_full,
   output logic                          almost_empty,
   output logic [clog2(DEPTH+1)-1:0]     high_water_mark
);

   localparam int PTR_WIDTH   = clog2(DEPTH);
   localparam int COUNT_WIDTH = clog2(DEPTH + 1);

   generate
      if (DEPTH < 2) begin : g_bad_depth
         $error("pipeline_fifo_buffer_levels: DEPTH must be at least 2");
      end
      if (ALMOST_FULL_LEVEL < 1 || ALMOST_FULL_LEVEL > DEPTH) begin : g_bad_full_level
         $error("pipeline_fifo_buffer_levels: ALMOST_FULL_LEVEL out of range");
      end
      if (ALMOST_EMPTY_LEVEL < 0 || ALMOST_EMPTY_LEVEL > DEPTH - 1) begin : g_bad_empty_level
         $error("pipeline_fifo_buffer_levels: ALMOST_EMPTY_LEVEL out of range");
      end
   endgenerate

   logic                   insert_s;
   logic                   remove_s;
   logic                   out_free_s;
   logic                   issue_s;
   logic [COUNT_WIDTH-1:0] count_s;
   logic [COUNT_WIDTH-1:0] unread_s;
   logic [PTR_WIDTH-1:0]   write_ptr_s;
   logic [PTR_WIDTH-1:0]   read_ptr_s;
   logic [WORD_WIDTH-1:0]  ram_q_s;
   logic                   ram_q_valid_r;
   logic                   output_valid_r;
   logic [WORD_WIDTH-1:0]  output_data_r;

   assign input_ready = (count_s != COUNT_WIDTH'(DEPTH)) & ~flush;
   assign insert_s    = input_valid & input_ready;
   assign remove_s    = output_valid_r & output_ready;
   assign out_free_s  = ~output_valid_r | output_ready;

   // Words in RAM not yet read: exclude the output register and the landed read.
   assign unread_s = count_s - COUNT_WIDTH'(output_valid_r) - COUNT_WIDTH'(ram_q_valid_r);
   assign issue_s  = (unread_s != {COUNT_WIDTH{1'b0}}) & (~ram_q_valid_r | out_free_s) & ~flush;

   pipeline_fifo_pointer_ctrl #(
      .DEPTH       (DEPTH),
      .PTR_WIDTH   (PTR_WIDTH),
      .COUNT_WIDTH (COUNT_WIDTH)
   ) u_pointer_ctrl (
      .clock         (clock),
      .clear         (clear),
      .flush         (flush),
      .insert        (insert_s),
      .read_issue    (issue_s),
      .remove        (remove_s),
      .write_pointer (write_ptr_s),
      .read_pointer  (read_ptr_s),
      .count         (count_s)
   );

   RAM_Simple_Dual_Port #(
      .WORD_WIDTH (WORD_WIDTH),
      .ADDR_WIDTH (PTR_WIDTH),
      .DEPTH      (DEPTH),
      .RAMSTYLE   (RAMSTYLE)
   ) u_ram (
      .clock         (clock),
      .wren          (insert_s),
      .write_address (write_ptr_s),
      .write_data    (input_data),
      .rden          (issue_s),
      .read_address  (read_ptr_s),
      .read_data     (ram_q_s)
   );

   // Tracks whether the RAM read register holds a word not yet moved to the output
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         ram_q_valid_r <= 1'b0;
      end else if (flush) begin
         ram_q_valid_r <= 1'b0;
      end else begin
         ram_q_valid_r <= issue_s | (ram_q_valid_r & ~out_free_s);
      end
   end

   // Output register: load a landed read when free, otherwise hold or empty on remove
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         output_valid_r <= 1'b0;
         output_data_r  <= {WORD_WIDTH{1'b0}};
      end else if (flush) begin
         output_valid_r <= 1'b0;
      end else if (ram_q_valid_r & out_free_s) begin
         output_valid_r <= 1'b1;
         output_data_r  <= ram_q_s;
      end else begin
         output_valid_r <= output_valid_r & ~output_ready;
      end
   end

   assign output_valid = output_valid_r;
   assign output_data  = output_data_r;
   assign count        = count_s;
   assign almost_full  = (count_s >= COUNT_WIDTH'(ALMOST_FULL_LEVEL));
   assign almost_empty = (count_s <= COUNT_WIDTH'(ALMOST_EMPTY_LEVEL));

`ifdef PIPELINE_FIFO_BUFFER_HIGH_WATER_EN
   logic [COUNT_WIDTH-1:0] count_next_s;
   logic [COUNT_WIDTH-1:0] high_water_r;

   // Occupancy after this edge, as seen by the peak tracker
   always_comb begin
      count_next_s = count_s + COUNT_WIDTH'(insert_s) - COUNT_WIDTH'(remove_s);
   end

   // Peak occupancy since the last clear or flush
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         high_water_r <= {COUNT_WIDTH{1'b0}};
      end else if (flush) begin
         high_water_r <= {COUNT_WIDTH{1'b0}};
      end else if (count_next_s > high_water_r) begin
         high_water_r <= count_next_s;
      end
   end

   assign high_water_mark = high_water_r;
`else
   assign high_water_mark = {COUNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_fifo_buffer_levels.sv
// Self-checking bench: DEPTH=16 and DEPTH=5 instances share stimulus, each
// compared every cycle against a queue-based model of the FIFO's rules.
module tb_pipeline_fifo_buffer_levels;

   logic       clock = 1'b0;
   logic       clear;
   logic       flush;
   logic       input_valid;
   logic [7:0] input_data;
   logic       output_ready;

   logic       ir_a, ov_a, af_a, ae_a;
   logic [7:0] od_a;
   logic [4:0] cnt_a, hwm_a;
   logic       ir_b, ov_b, af_b, ae_b;
   logic [7:0] od_b;
   logic [2:0] cnt_b, hwm_b;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   logic [7:0] qd [2][$];
   int         qt [2][$];
   int         hw [2];

   always #5 clock = ~clock;

   pipeline_fifo_buffer_levels #(.WORD_WIDTH(8), .DEPTH(16)) u_dut_a (
      .clock(clock), .clear(clear), .flush(flush),
      .input_valid(input_valid), .input_ready(ir_a), .input_data(input_data),
      .output_valid(ov_a), .output_ready(output_ready), .output_data(od_a),
      .count(cnt_a), .almost_full(af_a), .almost_empty(ae_a), .high_water_mark(hwm_a)
   );

   pipeline_fifo_buffer_levels #(.WORD_WIDTH(8), .DEPTH(5)) u_dut_b (
      .clock(clock), .clear(clear), .flush(flush),
      .input_valid(input_valid), .input_ready(ir_b), .input_data(input_data),
      .output_valid(ov_b), .output_ready(output_ready), .output_data(od_b),
      .count(cnt_b), .almost_full(af_b), .almost_empty(ae_b), .high_water_mark(hwm_b)
   );

   function automatic int depth_of(input int i);
      return (i == 0) ? 16 : 5;
   endfunction

   // Head word is visible once it has been held for two edges
   function automatic logic exp_valid(input int i);
      if (qd[i].size() == 0) return 1'b0;
      return (cyc - qt[i][0]) >= 2;
   endfunction

   task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, i, obs, exp);
      end
   endtask

   task automatic check_state(input logic fl);
      for (int i = 0; i < 2; i++) begin
         int n;
         int d;
         logic ev;
         logic [31:0] exp_hwm;
         n  = qd[i].size();
         d  = depth_of(i);
         ev = exp_valid(i);
`ifdef PIPELINE_FIFO_BUFFER_HIGH_WATER_EN
         exp_hwm = 32'(hw[i]);
`else
         exp_hwm = 32'd0;
`endif
         chk("count", i, (i == 0) ? 32'(cnt_a) : 32'(cnt_b), 32'(n));
         chk("input_ready", i, (i == 0) ? 32'(ir_a) : 32'(ir_b), 32'((n != d) && !fl));
         chk("output_valid", i, (i == 0) ? 32'(ov_a) : 32'(ov_b), 32'(ev));
         if (ev) begin
            chk("output_data", i, (i == 0) ? 32'(od_a) : 32'(od_b), 32'(qd[i][0]));
         end
         chk("almost_full", i, (i == 0) ? 32'(af_a) : 32'(af_b), 32'(n >= d - 2));
         chk("almost_empty", i, (i == 0) ? 32'(ae_a) : 32'(ae_b), 32'(n <= 1));
         chk("high_water_mark", i, (i == 0) ? 32'(hwm_a) : 32'(hwm_b), exp_hwm);
      end
   endtask

   // One clock cycle: drive after negedge, check, then advance the model at posedge
   task automatic cycle(input logic iv, input logic [7:0] din, input logic ordy, input logic fl);
      logic ins [2];
      logic rem [2];
      input_valid  = iv;
      input_data   = din;
      output_ready = ordy;
      flush        = fl;
      #1;
      check_state(fl);
      for (int i = 0; i < 2; i++) begin
         ins[i] = iv && !fl && (qd[i].size() != depth_of(i));
         rem[i] = exp_valid(i) && ordy;
      end
      @(posedge clock);
      cyc++;
      for (int i = 0; i < 2; i++) begin
         if (rem[i]) begin
            void'(qd[i].pop_front());
            void'(qt[i].pop_front());
         end
         if (fl) begin
            qd[i].delete();
            qt[i].delete();
            hw[i] = 0;
         end else if (ins[i]) begin
            qd[i].push_back(din);
            qt[i].push_back(cyc);
         end
         if (qd[i].size() > hw[i]) hw[i] = qd[i].size();
      end
      @(negedge clock);
   endtask

   // Asynchronous clear in the middle of a cycle; effects checked before the next edge
   task automatic mid_cycle_clear();
      input_valid  = 1'b0;
      output_ready = 1'b0;
      flush        = 1'b0;
      #2;
      clear = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) begin
         qd[i].delete();
         qt[i].delete();
         hw[i] = 0;
      end
      chk("clr_count", 0, 32'(cnt_a), 32'd0);
      chk("clr_count", 1, 32'(cnt_b), 32'd0);
      chk("clr_almost_empty", 0, 32'(ae_a), 32'd1);
      chk("clr_almost_empty", 1, 32'(ae_b), 32'd1);
      chk("clr_input_ready", 0, 32'(ir_a), 32'd1);
      chk("clr_input_ready", 1, 32'(ir_b), 32'd1);
      chk("clr_output_valid", 0, 32'(ov_a), 32'd0);
      chk("clr_output_data", 0, 32'(od_a), 32'd0);
      chk("clr_output_data", 1, 32'(od_b), 32'd0);
      chk("clr_high_water", 0, 32'(hwm_a), 32'd0);
      clear = 1'b0;
      @(negedge clock);
   endtask

   initial begin
      clear        = 1'b1;
      flush        = 1'b0;
      input_valid  = 1'b0;
      input_data   = 8'h00;
      output_ready = 1'b0;
      hw[0]        = 0;
      hw[1]        = 0;
      repeat (2) @(negedge clock);
      clear = 1'b0;
      @(negedge clock);
      mid_cycle_clear();

      // Single word: 0xA5 shows up two edges after it is accepted
      cycle(1'b1, 8'hA5, 1'b0, 1'b0);
      repeat (3) cycle(1'b0, 8'h00, 1'b0, 1'b0);

      // Clear with data in flight, then fill to full with the consumer stalled
      mid_cycle_clear();
      for (int k = 0; k < 16; k++) cycle(1'b1, 8'(k), 1'b0, 1'b0);
      repeat (2) cycle(1'b1, 8'hEE, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      repeat (20) cycle(1'b0, 8'h00, 1'b1, 1'b0);

      // Streaming at full rate with an incrementing pattern
      for (int k = 0; k < 100; k++) cycle(1'b1, 8'(k + 8'h40), 1'b1, 1'b0);
      repeat (20) cycle(1'b0, 8'h00, 1'b1, 1'b0);

      // Random stalls on both sides
      for (int k = 0; k < 200; k++) begin
         cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      end
      repeat (20) cycle(1'b0, 8'h00, 1'b1, 1'b0);

      // Flush while seven words are held and the head is being removed
      for (int k = 0; k < 7; k++) cycle(1'b1, 8'(8'h70 + k), 1'b0, 1'b0);
      repeat (3) cycle(1'b0, 8'h00, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b1);
      cycle(1'b1, 8'h3C, 1'b0, 1'b0);
      repeat (4) cycle(1'b0, 8'h00, 1'b1, 1'b0);

      // Peak occupancy of nine, drain, then flush
      for (int k = 0; k < 9; k++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
      repeat (3) cycle(1'b0, 8'h00, 1'b0, 1'b0);
      repeat (14) cycle(1'b0, 8'h00, 1'b1, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      repeat (2) cycle(1'b0, 8'h00, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipeline_fifo_buffer_levels.md
Name: pipeline_fifo_buffer_levels

Overview:
- Parametrised ready/valid FIFO buffer for decoupling a producer and a consumer, with a registered output stage, occupancy count, programmable almost-full/almost-empty flags and a synchronous flush.
- Drop-in successor for pipeline decoupling points that need flow-control hints (e.g. credit or burst scheduling) or need to discard in-flight data without a full reset.
- No combinational path between the input and output handshakes.

Parameters:
- WORD_WIDTH, 8, data width in bits.
- DEPTH, 16, total words held by the block, including the output stage; any integer >= 2, not restricted to powers of 2.
- ALMOST_FULL_LEVEL, DEPTH-2, almost_full asserts when count >= this value; legal range 1..DEPTH.
- ALMOST_EMPTY_LEVEL, 1, almost_empty asserts when count <= this value; legal range 0..DEPTH-1.
- RAMSTYLE, "MLAB, no_rw_check", storage implementation hint passed to the dual-port RAM.

Ports:
- clock  in  1  single clock; all logic is rising-edge.
- clear  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous discard of all contents.
- input_valid  in  1  producer has data.
- input_ready  out  1  block can accept a word.
- input_data  in  WORD_WIDTH  producer data.
- output_valid  out  1  output_data is valid.
- output_ready  in  1  consumer takes the word.
- output_data  out  WORD_WIDTH  head word.
- count  out  clog2(DEPTH+1)  words held, 0..DEPTH.
- almost_full  out  1  count >= ALMOST_FULL_LEVEL.
- almost_empty  out  1  count <= ALMOST_EMPTY_LEVEL.
- high_water_mark  out  clog2(DEPTH+1)  maximum count since clear or flush (see Optional Feature).

Behaviour:
- Reset values on clear, applied asynchronously:
  - count=0, output_valid=0, output_data=0, almost_full=0, almost_empty=1, high_water_mark=0.
  - input_ready=1.
  - Read and write pointers = 0.
- Handshake definitions:
  - insert = input_valid & input_ready.
  - remove = output_valid & output_ready.
  - Both may occur in the same cycle.
- Flow control:
  - input_ready = !(count == DEPTH) & !flush.
  - input_ready depends on registered state and flush only, never on output_ready.
- Occupancy:
  - count is the number of words accepted and not yet removed, including any word in the output register or in an in-flight RAM read.
  - Next count = count + insert - remove, so insert and remove in the same cycle leave count unchanged.
  - count never exceeds DEPTH and never underflows.
- Storage:
  - Simple dual-port synchronous RAM with DEPTH entries and 1-cycle read latency.
  - Write pointer and read pointer each increment by 1 and wrap from DEPTH-1 to 0.
  - The RAM never reads and writes the same address in the same cycle, so no write-forwarding logic is needed.
- Output stage:
  - output_valid is registered.
  - A RAM read issues when the RAM holds at least one unread word and the output register is empty, is being removed this cycle, or will be empty when the read lands.
  - The read pointer advances on issue.
  - output_data holds its value while output_valid=1 and output_ready=0.
- Latency and throughput:
  - A word inserted into an empty block at edge t appears with output_valid=1 after edge t+2.
  - Sustained throughput is 1 word/cycle in both directions once primed.
- Flags:
  - almost_full and almost_empty are combinational decodes of the registered count only.
- flush:
  - At the next edge, count, both pointers and output_valid all go to 0.
  - A remove in the flush cycle completes normally for the consumer, but count still goes to 0.
  - No insert is possible in the flush cycle, because input_ready is forced to 0.
- clear mid-operation:
  - clear asserted at any time returns every state element to its reset value immediately.
  - After clear deasserts, the first edge operates normally.
- Full and empty boundaries:
  - Full (count == DEPTH): input_ready=0; a remove in that cycle raises input_ready in the next cycle.
  - Empty (count == 0): output_valid=0; an insert is the only legal transition.
- Parameter checks: elaboration fails if DEPTH<2 or either threshold is out of range.

Optional Feature:
- Macro: PIPELINE_FIFO_BUFFER_HIGH_WATER_EN.
- Defined:
  - high_water_mark register updates to next count whenever next count > high_water_mark.
  - It resets to 0 on clear or flush.
- Undefined:
  - high_water_mark is tied to 0 and no register is generated.
  - The port stays present so the interface is identical in both builds.

Decomposition:
- Package pipeline_fifo_pkg contains:
  - clog2 function.
  - Count direction constants COUNT_UP and COUNT_DOWN.
- Existing RAM_Simple_Dual_Port is used for storage.
- One sub-module: pipeline_fifo_pointer_ctrl, which wraps the wrapping read/write pointers and the occupancy counter, takes insert/read-issue/remove/flush, and outputs pointers and count.
- The output stage and flags stay in the top level.

Test Plan:
- Reset and single word (DEPTH=16): clear pulse mid-cycle gives count=0, almost_empty=1, input_ready=1 at once; insert 0xA5 at edge t -> output_valid=1 with 0xA5 after t+2, count=1.
- Fill to full: output_ready=0, insert 16 words 0..15 -> input_ready=0 with count=16, almost_full=1 from count 14; one remove -> input_ready=1 next cycle, count=15.
- Streaming: input_valid=output_ready=1 for 100 cycles with an incrementing pattern -> output in order, no gaps after priming, count steady.
- Wrap-around with DEPTH=5: 23 words under random stall patterns on both sides -> order preserved, count never exceeds 5.
- Flush with count=7 during a simultaneous remove -> next cycle count=0, output_valid=0, pointers=0; the following insert of 0x3C emerges first.
- With PIPELINE_FIFO_BUFFER_HIGH_WATER_EN: peak count 9 -> high_water_mark=9, holds after draining, 0 after flush; without the macro -> high_water_mark always 0.
